// File: rtl/morse_decoder_pkg.sv
// Shared Morse constants, types and helpers for the receive and transmit paths.
// The transmitter adds the word-space size code and its own FSM state type.
package morse_decoder_pkg;

  localparam int MORSE_CHAR_WIDTH_MAX_C = 5;
  localparam int MORSE_SIZE_WIDTH_MAX_C = 3;

  // Default timing for a 12 MHz clock at roughly 10 words per minute.
  localparam int DOT_TICK_COUNT_C  = 1_440_000;
  localparam int DASH_TICK_COUNT_C = 3 * DOT_TICK_COUNT_C;
  localparam int CHAR_TICK_COUNT_C = 3 * DOT_TICK_COUNT_C;
  localparam int WORD_TICK_COUNT_C = 7 * DOT_TICK_COUNT_C;

  typedef logic [MORSE_CHAR_WIDTH_MAX_C-1:0] morse_sym_t;
  typedef logic [MORSE_SIZE_WIDTH_MAX_C-1:0] morse_size_t;

  // The receiver reports a word space as an all-zero pattern with a size code
  // that can never belong to a real character.
  localparam morse_sym_t  MORSE_SPACE_C      = '0;
  localparam morse_size_t MORSE_SPACE_SIZE_C = morse_size_t'(6);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    SYM_GAP  = 3'd2,
    CHAR_GAP = 3'd3,
    WORD_GAP = 3'd4
  } symbol_tx_fsm_t;

  function automatic int max_ticks(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/tx_duration_counter.sv
// Loadable down-counter timing each key-on / key-off interval of the keyer.
// It saturates at zero, so zero_o stays high until the next load.
module tx_duration_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/symbol_tx.sv
// Morse keyer: plays one dot/dash character (or a word space) per handshake
// on a registered key line with dot, dash, symbol, character and word timing.
module symbol_tx
  import morse_decoder_pkg::*;
#(
  parameter int DOT_TICKS      = DOT_TICK_COUNT_C,
  parameter int DASH_TICKS     = DASH_TICK_COUNT_C,
  parameter int SYM_GAP_TICKS  = DOT_TICK_COUNT_C,
  parameter int CHAR_GAP_TICKS = CHAR_TICK_COUNT_C,
  parameter int WORD_GAP_TICKS = WORD_TICK_COUNT_C
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              tvalid_i,
  output logic                              tready_o,
  input  logic [MORSE_CHAR_WIDTH_MAX_C-1:0] tdata_i,
  input  logic [MORSE_SIZE_WIDTH_MAX_C-1:0] tsize_i,
  output logic                              key_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int MAX_TICKS = max_ticks(DOT_TICKS, DASH_TICKS, SYM_GAP_TICKS,
                                       CHAR_GAP_TICKS, WORD_GAP_TICKS);
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  // Counter preload values: a state loaded with N-1 lasts exactly N cycles.
  localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_TICKS - 1);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_TICKS - 1);
  localparam logic [CNT_W-1:0] SYM_LD  = CNT_W'(SYM_GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] CHAR_LD = CNT_W'(CHAR_GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] WORD_LD = CNT_W'(WORD_GAP_TICKS - 1);

  symbol_tx_fsm_t state_d, state_q;
  morse_sym_t     sym_d,   sym_q;
  morse_size_t    size_d,  size_q;
  morse_size_t    idx_d,   idx_q;
  logic           key_d,   key_q;
  logic           err_d,   err_q;

  logic             accept;
  logic             is_space;
  logic             is_legal;
  logic             last_sym;
  logic             mark_dash;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  assign tready_o = (state_q == IDLE);
  assign accept   = tvalid_i && tready_o;
  assign is_space = (tdata_i == MORSE_SPACE_C) && (tsize_i == MORSE_SPACE_SIZE_C);
  assign is_legal = (tsize_i >= morse_size_t'(1)) &&
                    (tsize_i <= morse_size_t'(MORSE_CHAR_WIDTH_MAX_C));
  assign last_sym = ((idx_q + morse_size_t'(1)) == size_q);

  // First symbol comes straight from the bus; later ones from the latched
  // pattern, whose index was already advanced when the previous mark ended.
  assign mark_dash = (state_q == IDLE) ? tdata_i[0] : sym_q[idx_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && is_space) begin
          state_d = WORD_GAP;
        end else if (accept && is_legal) begin
          state_d = MARK;
        end
      end
      MARK: begin
        if (cnt_zero) begin
          state_d = last_sym ? CHAR_GAP : SYM_GAP;
        end
      end
      SYM_GAP: begin
        if (cnt_zero) begin
          state_d = MARK;
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_d     = (state_d == MARK);
    err_d     = accept && !is_space && !is_legal;
    busy_o    = (state_q != IDLE);
    // Every timed state is entered through a state change, so that is the load strobe.
    cnt_load  = (state_d != state_q) && (state_d != IDLE);
    cnt_value = '0;
    unique case (state_d)
      MARK:     cnt_value = mark_dash ? DASH_LD : DOT_LD;
      SYM_GAP:  cnt_value = SYM_LD;
      CHAR_GAP: cnt_value = CHAR_LD;
      WORD_GAP: cnt_value = WORD_LD;
      default:  cnt_value = '0;
    endcase
  end

  always_comb begin
    sym_d  = sym_q;
    size_d = size_q;
    idx_d  = idx_q;
    if (accept) begin
      sym_d  = tdata_i;
      size_d = tsize_i;
      idx_d  = '0;
    end else if ((state_q == MARK) && cnt_zero && !last_sym) begin
      idx_d = idx_q + morse_size_t'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sym_q  <= '0;
      size_q <= '0;
      idx_q  <= '0;
      key_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sym_q  <= sym_d;
      size_q <= size_d;
      idx_q  <= idx_d;
      key_q  <= key_d;
      err_q  <= err_d;
    end
  end

  assign key_o = key_q;
  assign err_o = err_q;

  tx_duration_counter #(
    .WIDTH (CNT_W)
  ) u_duration (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (cnt_load),
    .value_i (cnt_value),
    .zero_o  (cnt_zero)
  );

endmodule

// File: tb/tb_symbol_tx.sv
// Self-checking bench for symbol_tx: directed and random characters compared
// cycle by cycle against a key-waveform model built from the Morse timing rules.
module tb_symbol_tx;
  import morse_decoder_pkg::*;

  localparam int DOT  = 2;
  localparam int DASH = 6;
  localparam int SYM  = 2;
  localparam int CHR  = 6;
  localparam int WORD = 14;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tvalid_i;
  logic       tready_o;
  logic [4:0] tdata_i;
  logic [2:0] tsize_i;
  logic       key_o;
  logic       busy_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  bit exp_q[$];
  bit exp_illegal;

  always #5 clk = ~clk;

  symbol_tx #(
    .DOT_TICKS      (DOT),
    .DASH_TICKS     (DASH),
    .SYM_GAP_TICKS  (SYM),
    .CHAR_GAP_TICKS (CHR),
    .WORD_GAP_TICKS (WORD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tvalid_i (tvalid_i),
    .tready_o (tready_o),
    .tdata_i  (tdata_i),
    .tsize_i  (tsize_i),
    .key_o    (key_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Key level for each cycle after the accept, until the block is idle again.
  function automatic void build_expected(input logic [4:0] d, input logic [2:0] s);
    int on_len;
    int off_len;
    exp_q.delete();
    exp_illegal = 1'b0;
    if (d == MORSE_SPACE_C && s == MORSE_SPACE_SIZE_C) begin
      for (int k = 0; k < WORD; k++) exp_q.push_back(1'b0);
    end else if (s < 1 || s > 5) begin
      exp_illegal = 1'b1;
    end else begin
      for (int i = 0; i < int'(s); i++) begin
        on_len  = d[i] ? DASH : DOT;
        off_len = (i == int'(s) - 1) ? CHR : SYM;
        for (int k = 0; k < on_len; k++)  exp_q.push_back(1'b1);
        for (int k = 0; k < off_len; k++) exp_q.push_back(1'b0);
      end
    end
  endfunction

  // Entered and left one time unit after a rising edge (the start of a cycle).
  task automatic play(input logic [4:0] d, input logic [2:0] s, input string tag);
    build_expected(d, s);
    check({tag, "_ready_pre"}, tready_o, 1'b1);
    tvalid_i = 1'b1;
    tdata_i  = d;
    tsize_i  = s;
    @(posedge clk); #1;
    tvalid_i = 1'b0;
    tdata_i  = 5'($urandom);
    tsize_i  = 3'($urandom);
    if (exp_illegal) begin
      check({tag, "_err"},   err_o,    1'b1);
      check({tag, "_key"},   key_o,    1'b0);
      check({tag, "_busy"},  busy_o,   1'b0);
      check({tag, "_ready"}, tready_o, 1'b1);
      @(posedge clk); #1;
      check({tag, "_err_end"}, err_o, 1'b0);
      check({tag, "_key_end"}, key_o, 1'b0);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("%s_key_c%0d", tag, i + 1),   key_o,    exp_q[i]);
        check($sformatf("%s_busy_c%0d", tag, i + 1),  busy_o,   1'b1);
        check($sformatf("%s_ready_c%0d", tag, i + 1), tready_o, 1'b0);
        check($sformatf("%s_err_c%0d", tag, i + 1),   err_o,    1'b0);
        @(posedge clk); #1;
      end
      check({tag, "_ready_post"}, tready_o, 1'b1);
      check({tag, "_busy_post"},  busy_o,   1'b0);
      check({tag, "_key_post"},   key_o,    1'b0);
    end
  endtask

  initial begin
    logic [2:0] rs;
    resetn   = 1'b0;
    tvalid_i = 1'b0;
    tdata_i  = '0;
    tsize_i  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_key",   key_o,    1'b0);
    check("rst_busy",  busy_o,   1'b0);
    check("rst_err",   err_o,    1'b0);
    check("rst_ready", tready_o, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    play(5'b00010, 3'd2, "char_A");
    play(5'b11111, 3'd5, "char_0");
    play(MORSE_SPACE_C, MORSE_SPACE_SIZE_C, "space");
    play(5'b10110, 3'd0, "size0");
    play(5'b00000, 3'd7, "size7");
    play(5'b00000, 3'd0, "size0_zero");
    play(5'b01101, 3'd6, "size6_nonspace");
    play(5'b11110, 3'd1, "E_upper_junk");

    for (int n = 0; n < 8; n++) begin
      rs = 3'($urandom_range(1, 5));
      play(5'($urandom), rs, $sformatf("rand%0d", n));
    end

    // Two 'E' characters with tvalid held high the whole time.
    build_expected(5'b00000, 3'd1);
    tvalid_i = 1'b1;
    tdata_i  = 5'b00000;
    tsize_i  = 3'd1;
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("b2b_first_key_c%0d", i + 1), key_o,    exp_q[i]);
      check($sformatf("b2b_first_rdy_c%0d", i + 1), tready_o, 1'b0);
      @(posedge clk); #1;
    end
    check("b2b_idle_ready", tready_o, 1'b1);
    check("b2b_idle_key",   key_o,    1'b0);
    check("b2b_idle_busy",  busy_o,   1'b0);
    @(posedge clk); #1;
    tvalid_i = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("b2b_second_key_c%0d", i + 10), key_o,    exp_q[i]);
      check($sformatf("b2b_second_rdy_c%0d", i + 10), tready_o, 1'b0);
      @(posedge clk); #1;
    end
    check("b2b_done_ready", tready_o, 1'b1);

    // Reset in the middle of the dash of 'A'.
    tvalid_i = 1'b1;
    tdata_i  = 5'b00010;
    tsize_i  = 3'd2;
    @(posedge clk); #1;
    tvalid_i = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("rstmid_key_before", key_o, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("rstmid_key_async",   key_o,    1'b0);
    check("rstmid_busy_async",  busy_o,   1'b0);
    check("rstmid_ready_async", tready_o, 1'b1);
    check("rstmid_err_async",   err_o,    1'b0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_after_key_%0d", i),   key_o,    1'b0);
      check($sformatf("rstmid_after_busy_%0d", i),  busy_o,   1'b0);
      check($sformatf("rstmid_after_err_%0d", i),   err_o,    1'b0);
      check($sformatf("rstmid_after_ready_%0d", i), tready_o, 1'b1);
    end

    play(5'b00010, 3'd2, "char_A_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/symbol_tx.md
Name: symbol_tx

Overview:
Morse keyer and transmitter, the transmit-side counterpart of the symbol receiver. Accepts one Morse character per handshake as a dot/dash bit vector plus a symbol count, or a word-space marker. Plays it out on a single key line (LED or buzzer) with standard dot, dash, inter-symbol, inter-character and inter-word timing. Sits between the character encoder / loopback path and the board output pin.

Parameters:
DOT_TICKS, DOT_TICK_COUNT_C, key-on cycles for a dot (>=1)
DASH_TICKS, DASH_TICK_COUNT_C, key-on cycles for a dash (>=1)
SYM_GAP_TICKS, DOT_TICK_COUNT_C, key-off cycles between symbols of one character (>=1)
CHAR_GAP_TICKS, CHAR_TICK_COUNT_C, key-off cycles after the last symbol of a character (>=1)
WORD_GAP_TICKS, WORD_TICK_COUNT_C, key-off cycles for a word-space request (>=1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
tvalid_i  in  1  character valid
tready_o  out  1  block can accept a character
tdata_i  in  MORSE_CHAR_WIDTH_MAX_C  symbols; bit0 sent first; 1=dash, 0=dot
tsize_i  in  MORSE_SIZE_WIDTH_MAX_C  number of valid symbols in tdata_i
key_o  out  1  key line, 1 = tone/LED on
busy_o  out  1  transmission in progress (state != IDLE)
err_o  out  1  one-cycle pulse when an illegal character is dropped

Behaviour:
- Only one clock. Reset is asynchronous, active-low, applied immediately. Outputs in reset: key_o=0, busy_o=0, err_o=0, FSM=IDLE. tready_o is combinational (state==IDLE), so it reads 1 during and after reset.
- Accept: transfer occurs on a rising edge with tvalid_i && tready_o. tdata_i/tsize_i are latched into sym_r/size_r. The symbol index idx_r is cleared. tready_o drops the next cycle. No buffering beyond one character.
- Classification at accept:
  - Space: tdata_i==MORSE_SPACE_C && tsize_i==MORSE_SPACE_SIZE_C -> WORD_GAP.
  - Legal: 1<=tsize_i<=MORSE_CHAR_WIDTH_MAX_C -> MARK.
  - Otherwise: dropped. err_o pulses high the next cycle and the FSM stays IDLE.
- Duration counter: loaded with N-1 on entry to each timed state and decremented each cycle. The state exits on the cycle the count is 0, so each state lasts exactly N cycles.
- States:
  - IDLE: key_o=0. On a legal accept, go to MARK and load DOT or DASH per tdata_i[0].
  - MARK: key_o=1 for DOT_TICKS or DASH_TICKS. On expiry: if idx_r+1==size_r go to CHAR_GAP; else go to SYM_GAP and increment idx_r.
  - SYM_GAP: key_o=0 for SYM_GAP_TICKS. On expiry go to MARK with the duration selected by sym_r[idx_r].
  - CHAR_GAP: key_o=0 for CHAR_GAP_TICKS. On expiry go to IDLE.
  - WORD_GAP: key_o=0 for WORD_GAP_TICKS. On expiry go to IDLE.
- key_o is registered: it is high exactly in the cycles the FSM register holds MARK. First key-on cycle = accept cycle + 1.
- Back-to-back: tvalid_i held high with a new character is accepted in the first IDLE cycle. Consecutive characters are therefore separated by CHAR_GAP_TICKS + 1 key-off cycles. No combinational path from tvalid_i to tready_o.
- tdata_i bits at index >= tsize_i are ignored.
- Counter width: $clog2(max of all tick parameters + 1). No wrap-around is possible.
- Illegal FSM encoding: return to IDLE, key_o=0.
- Reset mid-character: key_o falls asynchronously and the character is discarded. No err_o.

Decomposition:
- Add to morse_decoder_pkg:
  - MORSE_SPACE_SIZE_C (size code paired with MORSE_SPACE_C, matching the receiver's space output)
  - symbol_tx_fsm_t enum {IDLE, MARK, SYM_GAP, CHAR_GAP, WORD_GAP}
- Reuse the existing MORSE_* width and tick constants.
- One sub-module: tx_duration_counter. It is a loadable down-counter with ports clk, resetn, load_i, value_i, zero_o, parameterised by WIDTH.

Test Plan:
- Params DOT=2, DASH=6, SYM_GAP=2, CHAR_GAP=6, WORD_GAP=14. Send 'A' (tdata=5'b00010, tsize=2), accepted cycle 0 -> key_o high cycles 1-2 and 5-10, low 3-4 and 11-16. tready_o=1 at cycle 17. busy_o=1 cycles 1-16.
- Send '0' (tdata=5'b11111, tsize=5) -> five 6-cycle key-on pulses separated by 2-cycle gaps. Last key-on cycle is 38. tready_o returns at cycle 45.
- Space (MORSE_SPACE_C, MORSE_SPACE_SIZE_C) -> key_o stays 0, busy_o=1 for cycles 1-14, tready_o=1 at cycle 15.
- tsize=0 and tsize=7 (non-space) -> err_o pulse the cycle after accept, key_o never high, tready_o stays 1.
- Back-to-back 'E' (tdata=0, tsize=1) with tvalid_i held high -> key-on pulses at cycles 1-2 and 10-11. Second accept in cycle 9.
- resetn asserted during the 'A' dash at cycle 7 -> key_o low before the next edge. After release, no key activity and tready_o=1.
